// File: rtl/exec_control_fsm.sv
// exec_control_fsm
// Execute-stage sequencer: accepts one decoded instruction per valid/ready
// handshake, resolves branches and jumps locally, drives the ALU through a
// start/done handshake with a timeout, and emits writeback, PC redirect,
// display and trap results as single-cycle registered pulses.
module exec_control_fsm #(
   parameter int XLEN        = 32,
   parameter int ALU_TIMEOUT = 16,
   parameter int IALIGN      = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   input  logic [XLEN-1:0] imm,
   input  logic            rd_valid,
   output logic            alu_start,
   input  logic            alu_done,
   input  logic [XLEN-1:0] alu_result,
   output logic            rd_write,
   output logic [XLEN-1:0] rd_data,
   output logic            pc_redirect,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] display_out,
   output logic            trap,
   output logic [1:0]      trap_cause,
   output logic            busy
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_EXEC     = 3'd1,
      ST_WAIT_ALU = 3'd2,
      ST_COMMIT   = 3'd3,
      ST_TRAP     = 3'd4
   } state_t;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;

   localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
   localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
   // Last counter value before the timeout fires: the counter holds the
   // number of completed WAIT_ALU cycles, so this edge ends cycle ALU_TIMEOUT.
   localparam logic [7:0]      TIMEOUT_LAST = 8'(ALU_TIMEOUT - 1);

   // Alignment check on the two low target bits; 16-bit alignment only
   // cares about bit 0, 32-bit alignment about both.
   function automatic logic target_misaligned(input logic [1:0] low_bits);
      logic bad;
      if (IALIGN == 16) begin
         bad = low_bits[0];
      end else begin
         bad = low_bits[1] | low_bits[0];
      end
      return bad;
   endfunction

   state_t          state_r;
   state_t          state_next_s;
   logic            commit_phase_r;
   logic [7:0]      cnt_r;

   logic [6:0]      opcode_r;
   logic [2:0]      func3_r;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] rs1_r;
   logic [XLEN-1:0] rs2_r;
   logic [XLEN-1:0] imm_r;
   logic            rd_valid_r;
   logic [XLEN-1:0] alu_res_r;

   logic            is_alu_s;
   logic            is_branch_s;
   logic            is_jal_s;
   logic            is_jalr_s;
   logic            is_jump_s;
   logic            br_func_ok_s;
   logic            br_taken_s;
   logic [XLEN-1:0] pc_target_s;
   logic [XLEN-1:0] jalr_target_s;
   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] link_s;
   logic            redirect_s;
   logic            misaligned_s;
   logic            wb_en_s;
   logic [XLEN-1:0] wb_data_s;
   logic            commit_fire_s;
   logic            accept_s;
   logic [1:0]      trap_cause_s;

   logic            issue_ready_r;
   logic            busy_r;
   logic            alu_start_r;
   logic            rd_write_r;
   logic [XLEN-1:0] rd_data_r;
   logic            pc_redirect_r;
   logic [XLEN-1:0] next_pc_r;
   logic [XLEN-1:0] display_out_r;
   logic            trap_r;
   logic [1:0]      trap_cause_r;

   assign issue_ready = issue_ready_r;
   assign busy        = busy_r;
   assign alu_start   = alu_start_r;
   assign rd_write    = rd_write_r;
   assign rd_data     = rd_data_r;
   assign pc_redirect = pc_redirect_r;
   assign next_pc     = next_pc_r;
   assign display_out = display_out_r;
   assign trap        = trap_r;
   assign trap_cause  = trap_cause_r;

   assign accept_s = (state_r == ST_IDLE) && issue_valid;

   // Classify the latched opcode into instruction classes.
   always_comb begin
      is_alu_s    = 1'b0;
      is_branch_s = 1'b0;
      is_jal_s    = 1'b0;
      is_jalr_s   = 1'b0;
      case (opcode_r)
         OP_REG, OP_IMM, OP_LOAD, OP_AUIPC, OP_LUI, OP_STORE: is_alu_s = 1'b1;
         OP_BRANCH: is_branch_s = 1'b1;
         OP_JAL:    is_jal_s    = 1'b1;
         OP_JALR:   is_jalr_s   = 1'b1;
         default:   is_alu_s    = 1'b0;
      endcase
   end

   assign is_jump_s    = is_jal_s | is_jalr_s;
   assign br_func_ok_s = (func3_r != 3'b010) && (func3_r != 3'b011);

   // Branch condition: signed compares reinterpret the operands, unsigned
   // compares use the raw bit patterns.
   always_comb begin
      br_taken_s = 1'b0;
      case (func3_r)
         3'b000:  br_taken_s = (rs1_r == rs2_r);
         3'b001:  br_taken_s = (rs1_r != rs2_r);
         3'b100:  br_taken_s = ($signed(rs1_r) <  $signed(rs2_r));
         3'b101:  br_taken_s = ($signed(rs1_r) >= $signed(rs2_r));
         3'b110:  br_taken_s = (rs1_r <  rs2_r);
         3'b111:  br_taken_s = (rs1_r >= rs2_r);
         default: br_taken_s = 1'b0;
      endcase
   end

   // Targets and link address; all sums wrap modulo 2^XLEN.
   always_comb begin
      pc_target_s   = pc_r + imm_r;
      jalr_target_s = (rs1_r + imm_r) & JALR_MASK;
      link_s        = pc_r + PC_STEP;
      if (is_jalr_s) begin
         target_s = jalr_target_s;
      end else begin
         target_s = pc_target_s;
      end
   end

   assign redirect_s    = (is_branch_s && br_taken_s) || is_jump_s;
   assign misaligned_s  = redirect_s && target_misaligned(target_s[1:0]);
   assign wb_en_s       = rd_valid_r && !is_branch_s && (opcode_r != OP_STORE);
   assign wb_data_s     = is_jump_s ? link_s : alu_res_r;
   // COMMIT spends its first cycle deciding; the pulses register at its end.
   assign commit_fire_s = (state_r == ST_COMMIT) && !commit_phase_r && !misaligned_s;

   // Next-state selection and the trap cause for any transition into TRAP.
   always_comb begin
      state_next_s = state_r;
      trap_cause_s = CAUSE_MISALIGN;
      case (state_r)
         ST_IDLE: begin
            if (issue_valid) begin
               state_next_s = ST_EXEC;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (is_alu_s) begin
               state_next_s = ST_WAIT_ALU;
            end else if (is_branch_s && br_func_ok_s) begin
               state_next_s = ST_COMMIT;
            end else if (is_jump_s) begin
               state_next_s = ST_COMMIT;
            end else begin
               state_next_s = ST_TRAP;
               trap_cause_s = CAUSE_ILLEGAL;
            end
         end
         ST_WAIT_ALU: begin
            if (alu_done) begin
               state_next_s = ST_COMMIT;
            end else if (cnt_r == TIMEOUT_LAST) begin
               state_next_s = ST_TRAP;
               trap_cause_s = CAUSE_TIMEOUT;
            end else begin
               state_next_s = ST_WAIT_ALU;
            end
         end
         ST_COMMIT: begin
            if (commit_phase_r) begin
               state_next_s = ST_IDLE;
            end else if (misaligned_s) begin
               state_next_s = ST_TRAP;
               trap_cause_s = CAUSE_MISALIGN;
            end else begin
               state_next_s = ST_COMMIT;
            end
         end
         ST_TRAP: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register, COMMIT phase flag and WAIT_ALU cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         commit_phase_r <= 1'b0;
         cnt_r          <= 8'd0;
      end else begin
         state_r        <= state_next_s;
         commit_phase_r <= (state_r == ST_COMMIT) && (state_next_s == ST_COMMIT);
         if ((state_r == ST_WAIT_ALU) && (state_next_s == ST_WAIT_ALU)) begin
            cnt_r <= cnt_r + 8'd1;
         end else begin
            cnt_r <= 8'd0;
         end
      end
   end

   // Capture the instruction fields at the handshake so the decoder may move on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_r   <= 7'd0;
         func3_r    <= 3'd0;
         pc_r       <= {XLEN{1'b0}};
         rs1_r      <= {XLEN{1'b0}};
         rs2_r      <= {XLEN{1'b0}};
         imm_r      <= {XLEN{1'b0}};
         rd_valid_r <= 1'b0;
      end else if (accept_s) begin
         opcode_r   <= opcode;
         func3_r    <= func3;
         pc_r       <= pc;
         rs1_r      <= rs1_value;
         rs2_r      <= rs2_value;
         imm_r      <= imm;
         rd_valid_r <= rd_valid;
      end
   end

   // Capture the ALU result on done; done outside WAIT_ALU is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_res_r <= {XLEN{1'b0}};
      end else if ((state_r == ST_WAIT_ALU) && alu_done) begin
         alu_res_r <= alu_result;
      end
   end

   // Registered outputs: strobes pulse for one cycle, data values hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_ready_r <= 1'b1;
         busy_r        <= 1'b0;
         alu_start_r   <= 1'b0;
         rd_write_r    <= 1'b0;
         rd_data_r     <= {XLEN{1'b0}};
         pc_redirect_r <= 1'b0;
         next_pc_r     <= {XLEN{1'b0}};
         display_out_r <= {XLEN{1'b0}};
         trap_r        <= 1'b0;
         trap_cause_r  <= 2'd0;
      end else begin
         issue_ready_r <= (state_next_s == ST_IDLE);
         busy_r        <= (state_next_s != ST_IDLE);
         alu_start_r   <= (state_r == ST_EXEC) && (state_next_s == ST_WAIT_ALU);
         rd_write_r    <= commit_fire_s && wb_en_s;
         pc_redirect_r <= commit_fire_s && redirect_s;
         trap_r        <= (state_next_s == ST_TRAP);
         if (commit_fire_s && wb_en_s) begin
            rd_data_r <= wb_data_s;
         end
         if (commit_fire_s && redirect_s) begin
            next_pc_r <= target_s;
         end
         if (commit_fire_s && is_alu_s) begin
            display_out_r <= alu_res_r;
         end
         if (state_next_s == ST_TRAP) begin
            trap_cause_r <= trap_cause_s;
         end
      end
   end

endmodule

// File: tb/tb_exec_control_fsm.sv
// Directed bench for exec_control_fsm. Two instances share the stimulus:
// dut_a uses IALIGN=32, dut_b uses IALIGN=16; both use ALU_TIMEOUT=4.
module tb_exec_control_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_valid = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic [2:0]  func3 = 3'd0;
   logic [31:0] pc = 32'd0;
   logic [31:0] rs1_value = 32'd0;
   logic [31:0] rs2_value = 32'd0;
   logic [31:0] imm = 32'd0;
   logic        rd_valid = 1'b0;
   logic        alu_done = 1'b0;
   logic [31:0] alu_result = 32'd0;

   logic        issue_ready_a, alu_start_a, rd_write_a, pc_redirect_a, trap_a, busy_a;
   logic [31:0] rd_data_a, next_pc_a, display_out_a;
   logic [1:0]  trap_cause_a;
   logic        issue_ready_b, alu_start_b, rd_write_b, pc_redirect_b, trap_b, busy_b;
   logic [31:0] rd_data_b, next_pc_b, display_out_b;
   logic [1:0]  trap_cause_b;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   exec_control_fsm #(.XLEN(32), .ALU_TIMEOUT(4), .IALIGN(32)) dut_a (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready_a),
      .opcode(opcode), .func3(func3), .pc(pc), .rs1_value(rs1_value),
      .rs2_value(rs2_value), .imm(imm), .rd_valid(rd_valid), .alu_start(alu_start_a),
      .alu_done(alu_done), .alu_result(alu_result), .rd_write(rd_write_a),
      .rd_data(rd_data_a), .pc_redirect(pc_redirect_a), .next_pc(next_pc_a),
      .display_out(display_out_a), .trap(trap_a), .trap_cause(trap_cause_a),
      .busy(busy_a)
   );

   exec_control_fsm #(.XLEN(32), .ALU_TIMEOUT(4), .IALIGN(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready_b),
      .opcode(opcode), .func3(func3), .pc(pc), .rs1_value(rs1_value),
      .rs2_value(rs2_value), .imm(imm), .rd_valid(rd_valid), .alu_start(alu_start_b),
      .alu_done(alu_done), .alu_result(alu_result), .rd_write(rd_write_b),
      .rd_data(rd_data_b), .pc_redirect(pc_redirect_b), .next_pc(next_pc_b),
      .display_out(display_out_b), .trap(trap_b), .trap_cause(trap_cause_b),
      .busy(busy_b)
   );

   // Free-running clock, rising edge active.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge and park on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present one instruction for a single handshake edge (E0), then scramble
   // the fields so the DUT must rely on its latched copy.
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pcv,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] immv,
                        input logic rdv);
      issue_valid = 1'b1;
      opcode      = op;
      func3       = f3;
      pc          = pcv;
      rs1_value   = a;
      rs2_value   = b;
      imm         = immv;
      rd_valid    = rdv;
      step();
      issue_valid = 1'b0;
      opcode      = 7'b1111111;
      func3       = 3'b011;
      pc          = 32'hDEADBEEF;
      rs1_value   = 32'h13579BDF;
      rs2_value   = 32'h2468ACE0;
      imm         = 32'h0BADF00D;
      rd_valid    = 1'b0;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", issue_ready_a, 32'd1);
      chk("rst_busy", busy_a, 32'd0);
      chk("rst_alu_start", alu_start_a, 32'd0);
      chk("rst_rd_write", rd_write_a, 32'd0);
      chk("rst_redirect", pc_redirect_a, 32'd0);
      chk("rst_trap", trap_a, 32'd0);
      chk("rst_rd_data", rd_data_a, 32'd0);
      chk("rst_next_pc", next_pc_a, 32'd0);
      chk("rst_display", display_out_a, 32'd0);
      chk("rst_cause", trap_cause_a, 32'd0);
      rst_n = 1'b1;
      step();
      chk("idle_ready", issue_ready_a, 32'd1);

      // bltu 0xFFFFFFFF < 1 unsigned: not taken
      issue(7'b1100011, 3'b110, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b1);
      chk("bltu_busy", busy_a, 32'd1);
      chk("bltu_ready_low", issue_ready_a, 32'd0);
      step();
      chk("bltu_no_start", alu_start_a, 32'd0);
      step();
      chk("bltu_no_redirect", pc_redirect_a, 32'd0);
      chk("bltu_no_wr", rd_write_a, 32'd0);
      chk("bltu_ready_e2", issue_ready_a, 32'd0);
      step();
      chk("bltu_ready_e3", issue_ready_a, 32'd1);
      chk("bltu_busy_e3", busy_a, 32'd0);

      // blt -1 < 1 signed: taken to 0x120
      issue(7'b1100011, 3'b100, 32'h100, 32'hFFFFFFFF, 32'h1, 32'h20, 1'b1);
      step();
      step();
      chk("blt_redirect", pc_redirect_a, 32'd1);
      chk("blt_next_pc", next_pc_a, 32'h120);
      chk("blt_no_wr", rd_write_a, 32'd0);
      step();
      chk("blt_redirect_drop", pc_redirect_a, 32'd0);
      chk("blt_next_pc_hold", next_pc_a, 32'h120);
      chk("blt_ready", issue_ready_a, 32'd1);

      // bgeu 0xFFFFFFFF >= 1: taken, backward target 0x200-8
      issue(7'b1100011, 3'b111, 32'h200, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFF8, 1'b0);
      step();
      step();
      chk("bgeu_redirect", pc_redirect_a, 32'd1);
      chk("bgeu_next_pc", next_pc_a, 32'h1F8);
      step();

      // bne with equal operands: not taken, next_pc holds
      issue(7'b1100011, 3'b001, 32'h200, 32'h7, 32'h7, 32'h40, 1'b0);
      step();
      step();
      chk("bne_no_redirect", pc_redirect_a, 32'd0);
      chk("bne_next_pc_hold", next_pc_a, 32'h1F8);
      step();

      // ADD with done three cycles after start (k=3): commit at E6
      issue(7'b0110011, 3'b000, 32'h400, 32'h1, 32'h2, 32'h0, 1'b1);
      step();
      chk("add_start", alu_start_a, 32'd1);
      step();
      chk("add_start_drop", alu_start_a, 32'd0);
      step();
      step();
      alu_done   = 1'b1;
      alu_result = 32'h1234;
      chk("add_wr_e4", rd_write_a, 32'd0);
      step();
      alu_done   = 1'b0;
      alu_result = 32'h0000DEAD;
      chk("add_wr_e5", rd_write_a, 32'd0);
      step();
      chk("add_wr", rd_write_a, 32'd1);
      chk("add_rd_data", rd_data_a, 32'h1234);
      chk("add_display", display_out_a, 32'h1234);
      chk("add_no_redirect", pc_redirect_a, 32'd0);
      chk("add_no_trap", trap_a, 32'd0);
      step();
      chk("add_wr_drop", rd_write_a, 32'd0);
      chk("add_ready", issue_ready_a, 32'd1);
      chk("add_display_hold", display_out_a, 32'h1234);

      // Store with done on the first WAIT_ALU cycle: display but no writeback
      issue(7'b0100011, 3'b010, 32'h500, 32'h10, 32'h20, 32'h4, 1'b1);
      step();
      chk("st_start", alu_start_a, 32'd1);
      alu_done   = 1'b1;
      alu_result = 32'h55AA;
      step();
      alu_done   = 1'b0;
      alu_result = 32'h0;
      step();
      chk("st_no_wr", rd_write_a, 32'd0);
      chk("st_display", display_out_a, 32'h55AA);
      chk("st_rd_data_hold", rd_data_a, 32'h1234);
      step();
      chk("st_ready", issue_ready_a, 32'd1);

      // ALU timeout: trap cause 1 four cycles after alu_start
      issue(7'b0010011, 3'b000, 32'h600, 32'h1, 32'h0, 32'h5, 1'b1);
      step();
      chk("to_start", alu_start_a, 32'd1);
      step();
      step();
      step();
      chk("to_no_trap_e4", trap_a, 32'd0);
      step();
      chk("to_trap", trap_a, 32'd1);
      chk("to_cause", trap_cause_a, 32'd1);
      chk("to_no_wr", rd_write_a, 32'd0);
      chk("to_ready_low", issue_ready_a, 32'd0);
      step();
      chk("to_trap_drop", trap_a, 32'd0);
      chk("to_ready", issue_ready_a, 32'd1);
      chk("to_cause_hold", trap_cause_a, 32'd1);

      // Branch with reserved func3 010: illegal
      issue(7'b1100011, 3'b010, 32'h700, 32'h1, 32'h1, 32'h8, 1'b1);
      step();
      chk("brill_trap", trap_a, 32'd1);
      chk("brill_cause", trap_cause_a, 32'd2);
      chk("brill_no_start", alu_start_a, 32'd0);
      chk("brill_no_wr", rd_write_a, 32'd0);
      step();
      chk("brill_ready", issue_ready_a, 32'd1);

      // JALR to 0x202: misaligned for IALIGN=32, fine for IALIGN=16
      issue(7'b1100111, 3'b000, 32'h40, 32'h203, 32'h0, 32'h0, 1'b1);
      step();
      chk("jalr_a_no_trap_e1", trap_a, 32'd0);
      step();
      chk("jalr_a_trap", trap_a, 32'd1);
      chk("jalr_a_cause", trap_cause_a, 32'd0);
      chk("jalr_a_no_wr", rd_write_a, 32'd0);
      chk("jalr_a_no_redirect", pc_redirect_a, 32'd0);
      chk("jalr_b_redirect", pc_redirect_b, 32'd1);
      chk("jalr_b_next_pc", next_pc_b, 32'h202);
      chk("jalr_b_wr", rd_write_b, 32'd1);
      chk("jalr_b_rd_data", rd_data_b, 32'h44);
      chk("jalr_b_no_trap", trap_b, 32'd0);
      step();
      chk("jalr_a_ready", issue_ready_a, 32'd1);
      chk("jalr_b_ready", issue_ready_b, 32'd1);

      // JAL: target pc+imm, link pc+4
      issue(7'b1101111, 3'b000, 32'h300, 32'h0, 32'h0, 32'h10, 1'b1);
      step();
      step();
      chk("jal_redirect", pc_redirect_a, 32'd1);
      chk("jal_next_pc", next_pc_a, 32'h310);
      chk("jal_wr", rd_write_a, 32'd1);
      chk("jal_rd_data", rd_data_a, 32'h304);
      step();

      // Unknown opcode 0001111: illegal
      issue(7'b0001111, 3'b000, 32'h800, 32'h0, 32'h0, 32'h0, 1'b1);
      step();
      chk("fence_trap", trap_a, 32'd1);
      chk("fence_cause", trap_cause_a, 32'd2);
      chk("fence_no_start", alu_start_a, 32'd0);
      step();
      chk("fence_ready", issue_ready_a, 32'd1);
      chk("fence_no_wr", rd_write_a, 32'd0);

      // Reset in WAIT_ALU abandons the instruction
      issue(7'b0110011, 3'b000, 32'h900, 32'h3, 32'h4, 32'h0, 1'b1);
      step();
      chk("rstop_start", alu_start_a, 32'd1);
      step();
      rst_n = 1'b0;
      #1;
      chk("rstop_ready", issue_ready_a, 32'd1);
      chk("rstop_busy", busy_a, 32'd0);
      chk("rstop_display", display_out_a, 32'd0);
      chk("rstop_next_pc", next_pc_a, 32'd0);
      alu_done    = 1'b1;
      alu_result  = 32'h7777;
      issue_valid = 1'b1;
      opcode      = 7'b0110011;
      rd_valid    = 1'b1;
      step();
      chk("rstop_no_wr", rd_write_a, 32'd0);
      chk("rstop_no_start", alu_start_a, 32'd0);
      step();
      chk("rstop_no_wr2", rd_write_a, 32'd0);
      issue_valid = 1'b0;
      rd_valid    = 1'b0;
      rst_n       = 1'b1;
      step();
      chk("rstop_ready_after", issue_ready_a, 32'd1);
      chk("rstop_idle_done_ignored", busy_a, 32'd0);
      alu_done = 1'b0;

      // Instruction after reset completes normally
      issue(7'b1101111, 3'b000, 32'h600, 32'h0, 32'h0, 32'h8, 1'b1);
      step();
      step();
      chk("post_redirect", pc_redirect_a, 32'd1);
      chk("post_next_pc", next_pc_a, 32'h608);
      chk("post_rd_data", rd_data_a, 32'h604);
      chk("post_wr", rd_write_a, 32'd1);
      step();
      chk("post_ready", issue_ready_a, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
